// File: rtl/br_amba_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : br_amba_axi_read_arbiter
//  Purpose  : Shares one AXI4 read initiator port (AR + R) among
//             NumRequesters AXI4 read target ports. AR is arbitrated
//             round-robin; R beats are routed back by requester-index bits
//             prepended to the ARID. Per-requester outstanding-burst
//             counters throttle each requester.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             target_ar*, target_arvalid/arready - per-requester AR (req 0 in LSBs)
//             target_r*, target_rvalid/rready    - R payload broadcast, per-requester valid
//             init_ar*, init_arvalid/arready     - shared AR towards the fabric
//             init_r*, init_rvalid/rready        - shared R from the fabric
//             idle        - no counts outstanding and no arvalid anywhere
//             err_bad_rid - sticky, R beat carried an out-of-range requester index
//  Revision : 1.0 - initial release
// ============================================================================
module br_amba_axi_read_arbiter #(
    parameter int NumRequesters  = 2,
    parameter int AddrWidth      = 12,
    parameter int DataWidth      = 32,
    parameter int IdWidth        = 1,
    parameter int ARUserWidth    = 1,
    parameter int RUserWidth     = 1,
    parameter int MaxOutstanding = 4,
    localparam int ReqIdxWidth   = $clog2(NumRequesters),
    localparam int InitIdWidth   = IdWidth + ReqIdxWidth
) (
    input  logic                                  clk,
    input  logic                                  rst,
    // Target-side AR
    input  logic [NumRequesters*AddrWidth-1:0]    target_araddr,
    input  logic [NumRequesters*IdWidth-1:0]      target_arid,
    input  logic [NumRequesters*8-1:0]            target_arlen,
    input  logic [NumRequesters*3-1:0]            target_arsize,
    input  logic [NumRequesters*2-1:0]            target_arburst,
    input  logic [NumRequesters*3-1:0]            target_arprot,
    input  logic [NumRequesters*ARUserWidth-1:0]  target_aruser,
    input  logic [NumRequesters-1:0]              target_arvalid,
    output logic [NumRequesters-1:0]              target_arready,
    // Target-side R
    output logic [NumRequesters*IdWidth-1:0]      target_rid,
    output logic [NumRequesters*DataWidth-1:0]    target_rdata,
    output logic [NumRequesters*RUserWidth-1:0]   target_ruser,
    output logic [NumRequesters*2-1:0]            target_rresp,
    output logic [NumRequesters-1:0]              target_rlast,
    output logic [NumRequesters-1:0]              target_rvalid,
    input  logic [NumRequesters-1:0]              target_rready,
    // Initiator-side AR
    output logic [AddrWidth-1:0]                  init_araddr,
    output logic [InitIdWidth-1:0]                init_arid,
    output logic [7:0]                            init_arlen,
    output logic [2:0]                            init_arsize,
    output logic [1:0]                            init_arburst,
    output logic [2:0]                            init_arprot,
    output logic [ARUserWidth-1:0]                init_aruser,
    output logic                                  init_arvalid,
    input  logic                                  init_arready,
    // Initiator-side R
    input  logic [InitIdWidth-1:0]                init_rid,
    input  logic [DataWidth-1:0]                  init_rdata,
    input  logic [RUserWidth-1:0]                 init_ruser,
    input  logic [1:0]                            init_rresp,
    input  logic                                  init_rlast,
    input  logic                                  init_rvalid,
    output logic                                  init_rready,
    // Status
    output logic                                  idle,
    output logic                                  err_bad_rid
);

    localparam int CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0]    c_max_cnt  = CntWidth'(MaxOutstanding);
    localparam logic [ReqIdxWidth-1:0] c_last_idx = ReqIdxWidth'(NumRequesters - 1);

    // State
    logic [ReqIdxWidth-1:0] r_ptr_q, w_ptr_d;
    logic                   r_lock_q, w_lock_d;
    logic [ReqIdxWidth-1:0] r_held_q, w_held_d;
    logic                   r_err_q, w_err_d;
    logic [CntWidth-1:0]    r_count_q [NumRequesters];
    logic [CntWidth-1:0]    w_count_d [NumRequesters];

    // Combinational
    logic [NumRequesters-1:0] w_eligible;
    logic [ReqIdxWidth-1:0]   w_sel;
    logic [ReqIdxWidth-1:0]   w_idx;
    logic                     w_found;
    logic [ReqIdxWidth-1:0]   w_grant;
    logic                     w_ar_hs;
    logic [ReqIdxWidth-1:0]   w_rid_idx;
    logic                     w_bad_rid;
    logic                     w_rready_sel;
    logic [NumRequesters-1:0] w_inc;
    logic [NumRequesters-1:0] w_dec;
    logic                     w_cnt_zero;
    logic [IdWidth-1:0]       w_arid_sel;

    // ------------------------------------------------------------------
    // Eligibility and round-robin selection
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NumRequesters; i++) begin
            w_eligible[i] = target_arvalid[i] && (r_count_q[i] < c_max_cnt);
        end
    end

    // Walk from the pointer, wrapping, and take the first eligible index.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = r_ptr_q;
        for (int i = 0; i < NumRequesters; i++) begin
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
            w_idx = (w_idx == c_last_idx) ? '0 : w_idx + 1'b1;
        end
    end

    // A pending (unaccepted) AR keeps its grant so the payload stays stable.
    assign w_grant      = r_lock_q ? r_held_q : w_sel;
    assign init_arvalid = !rst && (r_lock_q || w_found);
    assign w_ar_hs      = init_arvalid && init_arready;

    always_comb begin
        init_araddr  = '0;
        w_arid_sel   = '0;
        init_arlen   = '0;
        init_arsize  = '0;
        init_arburst = '0;
        init_arprot  = '0;
        init_aruser  = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            target_arready[i] = w_ar_hs && (w_grant == ReqIdxWidth'(i));
            if (w_grant == ReqIdxWidth'(i)) begin
                init_araddr  = target_araddr[i*AddrWidth +: AddrWidth];
                w_arid_sel   = target_arid[i*IdWidth +: IdWidth];
                init_arlen   = target_arlen[i*8 +: 8];
                init_arsize  = target_arsize[i*3 +: 3];
                init_arburst = target_arburst[i*2 +: 2];
                init_arprot  = target_arprot[i*3 +: 3];
                init_aruser  = target_aruser[i*ARUserWidth +: ARUserWidth];
            end
        end
    end

    assign init_arid = {w_grant, w_arid_sel};

    // ------------------------------------------------------------------
    // R routing
    // ------------------------------------------------------------------
    assign w_rid_idx = init_rid[InitIdWidth-1 -: ReqIdxWidth];

    // Out-of-range indices only exist when the count is not a power of two.
    generate
        if ((1 << ReqIdxWidth) != NumRequesters) begin : g_bad_idx
            assign w_bad_rid = (w_rid_idx >= ReqIdxWidth'(NumRequesters));
        end else begin : g_no_bad_idx
            assign w_bad_rid = 1'b0;
        end
    endgenerate

    always_comb begin
        w_rready_sel = 1'b0;
        for (int i = 0; i < NumRequesters; i++) begin
            target_rvalid[i] = !rst && init_rvalid && !w_bad_rid
                               && (w_rid_idx == ReqIdxWidth'(i));
            if (w_rid_idx == ReqIdxWidth'(i)) begin
                w_rready_sel = target_rready[i];
            end
        end
    end

    // Beats for a nonexistent requester are sunk so the fabric cannot stall.
    assign init_rready  = !rst && (w_bad_rid || w_rready_sel);

    assign target_rid   = {NumRequesters{init_rid[IdWidth-1:0]}};
    assign target_rdata = {NumRequesters{init_rdata}};
    assign target_ruser = {NumRequesters{init_ruser}};
    assign target_rresp = {NumRequesters{init_rresp}};
    assign target_rlast = {NumRequesters{init_rlast}};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_ptr_d  = r_ptr_q;
        w_lock_d = r_lock_q;
        w_held_d = r_held_q;
        if (w_ar_hs) begin
            w_ptr_d  = (w_grant == c_last_idx) ? '0 : w_grant + 1'b1;
            w_lock_d = 1'b0;
        end else if (init_arvalid) begin
            w_lock_d = 1'b1;
            w_held_d = w_grant;
        end
    end

    assign w_err_d = r_err_q || (init_rvalid && w_bad_rid);

    always_comb begin
        w_cnt_zero = 1'b1;
        for (int i = 0; i < NumRequesters; i++) begin
            w_inc[i] = w_ar_hs && (w_grant == ReqIdxWidth'(i));
            w_dec[i] = init_rvalid && init_rready && init_rlast && !w_bad_rid
                       && (w_rid_idx == ReqIdxWidth'(i));
            w_count_d[i] = r_count_q[i];
            if (w_inc[i] && !w_dec[i]) begin
                w_count_d[i] = r_count_q[i] + 1'b1;
            end else if (!w_inc[i] && w_dec[i]) begin
                w_count_d[i] = r_count_q[i] - 1'b1;
            end
            w_cnt_zero = w_cnt_zero && (r_count_q[i] == '0);
        end
    end

    assign idle        = w_cnt_zero && !(|target_arvalid) && !init_arvalid;
    assign err_bad_rid = r_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q  <= '0;
            r_lock_q <= 1'b0;
            r_held_q <= '0;
            r_err_q  <= 1'b0;
            for (int i = 0; i < NumRequesters; i++) begin
                r_count_q[i] <= '0;
            end
        end else begin
            r_ptr_q  <= w_ptr_d;
            r_lock_q <= w_lock_d;
            r_held_q <= w_held_d;
            r_err_q  <= w_err_d;
            for (int i = 0; i < NumRequesters; i++) begin
                r_count_q[i] <= w_count_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_chk
            a_arvalid_stable: assume property (@(posedge clk) disable iff (rst)
                (target_arvalid[gi] && !target_arready[gi]) |=> target_arvalid[gi]);
            a_no_underflow: assert property (@(posedge clk) disable iff (rst)
                !(w_dec[gi] && !w_inc[gi] && (r_count_q[gi] == '0)));
            a_no_overflow: assert property (@(posedge clk) disable iff (rst)
                !(w_inc[gi] && !w_dec[gi] && (r_count_q[gi] == c_max_cnt)));
        end
    endgenerate

    a_ar_stable: assert property (@(posedge clk) disable iff (rst)
        (init_arvalid && !init_arready) |=>
            (init_arvalid && $stable(init_araddr) && $stable(init_arid)
             && $stable(init_arlen) && $stable(init_arsize) && $stable(init_arburst)
             && $stable(init_arprot) && $stable(init_aruser)));
    a_arready_onehot0: assert property (@(posedge clk) $onehot0(target_arready));
    a_rvalid_onehot0:  assert property (@(posedge clk) $onehot0(target_rvalid));

endmodule
`default_nettype wire
